// File: rtl/rto_dds_command_decoder.sv
// Decodes timestamped real-time-output entries into DDS frequency, phase and
// amplitude registers, with a linear amplitude-ramp engine.
module rto_dds_command_decoder #(
    parameter int unsigned FREQ_WIDTH  = 48,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned AMP_WIDTH   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [127:0]           rto_in,
    output logic [FREQ_WIDTH-1:0]  dds_freq,
    output logic [PHASE_WIDTH-1:0] dds_phase,
    output logic [AMP_WIDTH-1:0]   dds_amp,
    output logic                   dds_update,
    output logic                   ramp_busy,
    output logic                   ramp_done,
    output logic                   opcode_error,
    output logic [127:0]           opcode_error_data,
    output logic [63:0]            last_timestamp
);

    localparam int unsigned TS_LSB   = 64;
    localparam int unsigned OPC_LSB  = 60;
    localparam int unsigned STEP_LSB = 16;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_SET_FREQ  = 4'h1;
    localparam logic [3:0] OP_SET_PHASE = 4'h2;
    localparam logic [3:0] OP_UPDATE    = 4'h3;
    localparam logic [3:0] OP_SET_AMP   = 4'h4;
    localparam logic [3:0] OP_RAMP_AMP  = 4'h5;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t                 state;
    logic [FREQ_WIDTH-1:0]  shadow_freq;
    logic [PHASE_WIDTH-1:0] shadow_phase;
    logic [AMP_WIDTH-1:0]   ramp_target;
    logic [AMP_WIDTH-1:0]   ramp_step;

    logic [3:0]             opcode;
    logic [AMP_WIDTH-1:0]   cmd_amp;
    logic [AMP_WIDTH-1:0]   cmd_step;
    logic                   ramp_up;
    logic [AMP_WIDTH:0]     ramp_diff;

    // Payload field extraction.
    assign opcode   = rto_in[OPC_LSB+3:OPC_LSB];
    assign cmd_amp  = rto_in[AMP_WIDTH-1:0];
    assign cmd_step = rto_in[STEP_LSB+AMP_WIDTH-1:STEP_LSB];

    assign ramp_busy = (state == RAMP);

    // Distance to the ramp target, one bit wider so it can never wrap.
    always_comb begin
        ramp_up   = (ramp_target > dds_amp);
        ramp_diff = '0;
        if (ramp_up) begin
            ramp_diff = {1'b0, ramp_target} - {1'b0, dds_amp};
        end else begin
            ramp_diff = {1'b0, dds_amp} - {1'b0, ramp_target};
        end
    end

    // Ramp stepping first, then command decode so a command overrides the step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            shadow_freq       <= '0;
            shadow_phase      <= '0;
            ramp_target       <= '0;
            ramp_step         <= '0;
            dds_freq          <= '0;
            dds_phase         <= '0;
            dds_amp           <= '0;
            dds_update        <= 1'b0;
            ramp_done         <= 1'b0;
            opcode_error      <= 1'b0;
            opcode_error_data <= '0;
            last_timestamp    <= '0;
        end else begin
            dds_update   <= 1'b0;
            ramp_done    <= 1'b0;
            opcode_error <= 1'b0;

            if (state == RAMP) begin
                if (ramp_diff <= {1'b0, ramp_step}) begin
                    dds_amp   <= ramp_target;
                    ramp_done <= 1'b1;
                    state     <= IDLE;
                end else if (ramp_up) begin
                    dds_amp <= dds_amp + ramp_step;
                end else begin
                    dds_amp <= dds_amp - ramp_step;
                end
            end

            if (cmd_valid) begin
                last_timestamp <= rto_in[127:TS_LSB];
                case (opcode)
                    OP_NOP: begin
                    end
                    OP_SET_FREQ: begin
                        shadow_freq <= rto_in[FREQ_WIDTH-1:0];
                    end
                    OP_SET_PHASE: begin
                        shadow_phase <= rto_in[PHASE_WIDTH-1:0];
                    end
                    OP_UPDATE: begin
                        dds_freq   <= shadow_freq;
                        dds_phase  <= shadow_phase;
                        dds_update <= 1'b1;
                    end
                    OP_SET_AMP: begin
                        dds_amp   <= cmd_amp;
                        ramp_done <= 1'b0;
                        state     <= IDLE;
                    end
                    OP_RAMP_AMP: begin
                        ramp_target <= cmd_amp;
                        ramp_step   <= cmd_step;
                        if ((cmd_step == '0) || (cmd_amp == dds_amp)) begin
                            // Degenerate ramp collapses to an immediate set.
                            dds_amp   <= cmd_amp;
                            ramp_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Retarget holds the current amplitude this cycle.
                            dds_amp   <= dds_amp;
                            ramp_done <= 1'b0;
                            state     <= RAMP;
                        end
                    end
                    default: begin
                        opcode_error      <= 1'b1;
                        opcode_error_data <= rto_in;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rto_dds_command_decoder.sv
// Directed bench for rto_dds_command_decoder with a cycle-level reference model.
module tb_rto_dds_command_decoder;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic [127:0] rto_in;
    logic [47:0]  dds_freq;
    logic [15:0]  dds_phase;
    logic [13:0]  dds_amp;
    logic         dds_update;
    logic         ramp_busy;
    logic         ramp_done;
    logic         opcode_error;
    logic [127:0] opcode_error_data;
    logic [63:0]  last_timestamp;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    rto_dds_command_decoder dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .rto_in            (rto_in),
        .dds_freq          (dds_freq),
        .dds_phase         (dds_phase),
        .dds_amp           (dds_amp),
        .dds_update        (dds_update),
        .ramp_busy         (ramp_busy),
        .ramp_done         (ramp_done),
        .opcode_error      (opcode_error),
        .opcode_error_data (opcode_error_data),
        .last_timestamp    (last_timestamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: integer amplitude arithmetic, state held as plain values.
    logic [47:0]  m_sfreq, m_freq;
    logic [15:0]  m_sphase, m_phase;
    int           m_amp, m_tgt, m_step;
    bit           m_ramp, m_upd, m_done, m_err;
    logic [127:0] m_errdata;
    logic [63:0]  m_ts;

    always @(posedge clk) begin : model
        int a, t, s, d;
        bit r, up, dn, er;
        logic [47:0]  sf, f;
        logic [15:0]  sp, p;
        logic [127:0] ed;
        logic [63:0]  ts;
        a = m_amp; t = m_tgt; s = m_step; r = m_ramp;
        sf = m_sfreq; sp = m_sphase; f = m_freq; p = m_phase;
        ed = m_errdata; ts = m_ts; up = 0; dn = 0; er = 0;
        if (reset) begin
            a = 0; t = 0; s = 0; r = 0; sf = '0; sp = '0; f = '0; p = '0;
            ed = '0; ts = '0;
        end else begin
            if (r) begin
                d = t - a;
                if (((d < 0) ? -d : d) <= s) begin
                    a = t; dn = 1; r = 0;
                end else begin
                    a = a + ((d > 0) ? s : -s);
                end
            end
            if (cmd_valid) begin
                ts = rto_in[127:64];
                case (rto_in[63:60])
                    4'h0: ;
                    4'h1: sf = rto_in[47:0];
                    4'h2: sp = rto_in[15:0];
                    4'h3: begin f = m_sfreq; p = m_sphase; up = 1; end
                    4'h4: begin a = int'(rto_in[13:0]); r = 0; dn = 0; end
                    4'h5: begin
                        t = int'(rto_in[13:0]);
                        s = int'(rto_in[29:16]);
                        if (s == 0 || t == m_amp) begin
                            a = t; r = 0; dn = 1;
                        end else begin
                            a = m_amp; r = 1; dn = 0;
                        end
                    end
                    default: begin er = 1; ed = rto_in; end
                endcase
            end
        end
        m_amp <= a; m_tgt <= t; m_step <= s; m_ramp <= r;
        m_sfreq <= sf; m_sphase <= sp; m_freq <= f; m_phase <= p;
        m_errdata <= ed; m_ts <= ts; m_upd <= up; m_done <= dn; m_err <= er;
    end

    // Compare every output against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dds_freq", 128'(dds_freq), 128'(m_freq));
            chk("dds_phase", 128'(dds_phase), 128'(m_phase));
            chk("dds_amp", 128'(dds_amp), 128'(m_amp));
            chk("dds_update", 128'(dds_update), 128'(m_upd));
            chk("ramp_busy", 128'(ramp_busy), 128'(m_ramp));
            chk("ramp_done", 128'(ramp_done), 128'(m_done));
            chk("opcode_error", 128'(opcode_error), 128'(m_err));
            chk("opcode_error_data", opcode_error_data, m_errdata);
            chk("last_timestamp", 128'(last_timestamp), 128'(m_ts));
        end
    end

    // Drive one command; returns just after the edge that sampled it.
    task automatic cmd(input logic [3:0] op, input logic [63:0] ts, input logic [59:0] body);
        cmd_valid = 1'b1;
        rto_in    = {ts, op, body};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rto_in    = '0;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [59:0] ramp_body(input int step, input int target);
        return (60'(step) << 16) | 60'(target);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dones;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        rto_in    = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        idle(1);
        reset = 1'b0;
        idle(2);
        chk("reset amp", 128'(dds_amp), 128'(0));
        chk("reset busy", 128'(ramp_busy), 128'(0));
        chk("reset ts", 128'(last_timestamp), 128'(0));

        // Shadow registers only reach the outputs on UPDATE.
        cmd(4'h1, 64'd1, 60'h0000_1234_5678);
        chk("freq before update", 128'(dds_freq), 128'(0));
        cmd(4'h2, 64'd2, 60'h4000);
        chk("phase before update", 128'(dds_phase), 128'(0));
        cmd(4'h3, 64'd3, 60'h0);
        chk("update pulse", 128'(dds_update), 128'(1));
        chk("freq after update", 128'(dds_freq), 128'h1234_5678);
        chk("phase after update", 128'(dds_phase), 128'h4000);
        idle(1);
        chk("update pulse end", 128'(dds_update), 128'(0));

        // 100 -> 110 step 4.
        cmd(4'h4, 64'd4, 60'd100);
        chk("set amp 100", 128'(dds_amp), 128'(100));
        cmd(4'h5, 64'd5, ramp_body(4, 110));
        chk("ramp hold", 128'(dds_amp), 128'(100));
        chk("ramp busy 1", 128'(ramp_busy), 128'(1));
        idle(1);
        chk("ramp 104", 128'(dds_amp), 128'(104));
        idle(1);
        chk("ramp 108", 128'(dds_amp), 128'(108));
        chk("ramp busy 3", 128'(ramp_busy), 128'(1));
        idle(1);
        chk("ramp 110", 128'(dds_amp), 128'(110));
        chk("ramp done", 128'(ramp_done), 128'(1));
        chk("ramp idle", 128'(ramp_busy), 128'(0));
        idle(1);
        chk("ramp done end", 128'(ramp_done), 128'(0));

        // Full-scale ramps up and down without wrapping.
        cmd(4'h4, 64'd6, 60'd0);
        cmd(4'h5, 64'd7, ramp_body(14'h3000, 14'h3FFF));
        idle(1);
        chk("up 3000", 128'(dds_amp), 128'h3000);
        idle(1);
        chk("up 3fff", 128'(dds_amp), 128'h3FFF);
        cmd(4'h5, 64'd8, ramp_body(14'h3000, 0));
        idle(1);
        chk("down 0fff", 128'(dds_amp), 128'h0FFF);
        idle(1);
        chk("down 0", 128'(dds_amp), 128'(0));
        chk("down done", 128'(ramp_done), 128'(1));

        // SET_AMP aborts a ramp without ramp_done.
        cmd(4'h5, 64'd9, ramp_body(10, 1000));
        idle(3);
        chk("abort pre", 128'(dds_amp), 128'(30));
        cmd(4'h4, 64'd10, 60'd50);
        chk("abort amp", 128'(dds_amp), 128'(50));
        chk("abort busy", 128'(ramp_busy), 128'(0));
        chk("abort no done", 128'(ramp_done), 128'(0));
        idle(2);
        chk("abort hold", 128'(dds_amp), 128'(50));

        // Retarget mid-ramp down to 0.
        cmd(4'h5, 64'd11, ramp_body(10, 1000));
        idle(5);
        chk("retarget pre", 128'(dds_amp), 128'(100));
        cmd(4'h5, 64'd12, ramp_body(20, 0));
        chk("retarget hold", 128'(dds_amp), 128'(100));
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (ramp_done) dones++;
        end
        chk("retarget final", 128'(dds_amp), 128'(0));
        chk("retarget one done", 128'(dones), 128'(1));

        // Degenerate ramps collapse to a set with ramp_done.
        cmd(4'h5, 64'd13, ramp_body(0, 77));
        chk("step0 amp", 128'(dds_amp), 128'(77));
        chk("step0 done", 128'(ramp_done), 128'(1));
        chk("step0 busy", 128'(ramp_busy), 128'(0));
        cmd(4'h5, 64'd14, ramp_body(5, 77));
        chk("same tgt done", 128'(ramp_done), 128'(1));

        // Invalid opcode.
        cmd(4'h9, 64'hABCD, 60'h123_4567_89AB_CDEF);
        chk("err pulse", 128'(opcode_error), 128'(1));
        chk("err data", opcode_error_data, {64'hABCD, 4'h9, 60'h123_4567_89AB_CDEF});
        chk("err ts", 128'(last_timestamp), 128'hABCD);
        chk("err amp", 128'(dds_amp), 128'(77));
        chk("err freq", 128'(dds_freq), 128'h1234_5678);
        idle(1);
        chk("err pulse end", 128'(opcode_error), 128'(0));

        // Frequency traffic back-to-back during a ramp.
        cmd(4'h5, 64'd15, ramp_body(3, 90));
        cmd(4'h1, 64'd16, 60'hABC);
        cmd(4'h2, 64'd17, 60'h1111);
        cmd(4'h3, 64'd18, 60'h0);
        chk("b2b freq", 128'(dds_freq), 128'hABC);
        chk("b2b amp", 128'(dds_amp), 128'(86));
        idle(4);
        chk("b2b final", 128'(dds_amp), 128'(90));

        // Reset mid-ramp.
        cmd(4'h5, 64'd19, ramp_body(1, 0));
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("rst amp", 128'(dds_amp), 128'(0));
        chk("rst busy", 128'(ramp_busy), 128'(0));
        chk("rst freq", 128'(dds_freq), 128'(0));
        chk("rst errdata", opcode_error_data, 128'(0));
        reset = 1'b0;
        idle(1);

        cmd(4'h0, 64'h55, 60'h0);
        chk("nop ts", 128'(last_timestamp), 128'h55);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rto_dds_command_decoder.md
Name: rto_dds_command_decoder

Overview:
- Sits directly downstream of the per-channel real-time-output core in each DAC controller.
- Consumes one 128-bit timestamped entry per counter-match pulse: [127:64] timestamp, [63:0] command payload.
- Decodes the payload into DDS frequency, phase and amplitude registers and drives them to the DDS/DAC sample path.
- Contains a linear amplitude-ramp engine so a single timed command can produce a smooth amplitude transition without one FIFO entry per step.

Parameters:
FREQ_WIDTH, 48, frequency tuning word width
PHASE_WIDTH, 16, phase offset width
AMP_WIDTH, 14, amplitude width; ramp step field uses the same width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
cmd_valid  input  1  single-cycle pulse; rto_in is valid in the same cycle
rto_in  input  128  matched entry; [127:64] timestamp, [63:0] payload
dds_freq  output  FREQ_WIDTH  active frequency tuning word
dds_phase  output  PHASE_WIDTH  active phase offset
dds_amp  output  AMP_WIDTH  active amplitude, unsigned
dds_update  output  1  one-cycle pulse when dds_freq/dds_phase change
ramp_busy  output  1  high while a ramp is in progress
ramp_done  output  1  one-cycle pulse when a ramp reaches its target
opcode_error  output  1  one-cycle pulse on an unknown opcode
opcode_error_data  output  128  last rto_in that caused opcode_error
last_timestamp  output  64  timestamp of the last accepted command

Behaviour:
- Reset is synchronous, active-high, clock clk. On reset, all outputs and internal registers go to 0: shadow frequency/phase, ramp target/step, and the FSM returns to IDLE.
- Reset mid-ramp aborts the ramp immediately; dds_amp becomes 0.
- Payload format:
  - [63:60] opcode.
  - 0x0 NOP: no effect except updating last_timestamp.
  - 0x1 SET_FREQ: shadow_freq <= [FREQ_WIDTH-1:0].
  - 0x2 SET_PHASE: shadow_phase <= [PHASE_WIDTH-1:0].
  - 0x3 UPDATE: dds_freq <= shadow_freq; dds_phase <= shadow_phase; pulse dds_update.
  - 0x4 SET_AMP: dds_amp <= [AMP_WIDTH-1:0]; aborts any ramp; FSM goes to IDLE; no ramp_done pulse.
  - 0x5 RAMP_AMP: target <= [AMP_WIDTH-1:0]; step <= [16+AMP_WIDTH-1:16]. If step==0, or target equals the current dds_amp, treat it as SET_AMP to target and pulse ramp_done next cycle. Otherwise go to RAMP.
  - 0x6-0xF: invalid. Pulse opcode_error and latch rto_in into opcode_error_data; no other state changes.
- Latency: cmd_valid in cycle N -> register updates and pulses visible in cycle N+1. last_timestamp updates in cycle N+1 for every cmd_valid, including invalid opcodes.
- cmd_valid low: all pulse outputs are 0 and registers hold.
- Ramp FSM:
  - States are IDLE and RAMP; ramp_busy = (state==RAMP).
  - First step is applied in the cycle after entering RAMP.
  - Each RAMP cycle computes diff = |target - dds_amp| at AMP_WIDTH+1 bits, unsigned.
    - If diff <= step: dds_amp <= target, pulse ramp_done, go to IDLE.
    - Else: dds_amp <= dds_amp ± step toward target.
  - Arithmetic never wraps: overshoot is impossible by construction, and the final step is clamped to target.
- Simultaneous events:
  - RAMP_AMP arriving while in RAMP retargets from the current dds_amp; the new target/step take effect on the next cycle and no ramp_done pulse is issued for the old ramp.
  - SET_AMP arriving while in RAMP overrides the ramp step in that cycle.
  - SET_FREQ/SET_PHASE/UPDATE do not disturb a ramp in progress.
- Back-to-back cmd_valid on consecutive cycles must be accepted with no loss. The block has no backpressure.

Test Plan:
- Reset then idle -> all outputs 0, ramp_busy=0. Assert reset in a later cycle -> outputs return to 0 next cycle.
- SET_FREQ 0x0000_1234_5678, then SET_PHASE 0x4000, then UPDATE on consecutive cycles -> dds_freq/dds_phase unchanged until the UPDATE cycle +1. dds_update pulses exactly once, then dds_freq=0x123456780000>>16 field as written (0x1234_5678) and dds_phase=0x4000.
- SET_AMP 100, then RAMP_AMP target 110, step 4 -> dds_amp sequence 100,104,108,110; ramp_done pulses in the cycle dds_amp becomes 110; ramp_busy high for 3 cycles.
- RAMP_AMP from 0 to 0x3FFF step 0x3000, and a downward RAMP_AMP from 0x3FFF to 0 step 0x3000 -> sequences 0x3000,0x3FFF and 0x0FFF,0, with no wrap.
- Mid-ramp SET_AMP 50 while ramping 0->1000 step 10 -> dds_amp=50 next cycle, ramp_busy=0, no ramp_done pulse. A separate mid-ramp RAMP_AMP retarget to 0 step 20 -> ramp descends from the current value to 0 with a single ramp_done pulse.
- Opcode 0x9 with timestamp 0xABCD -> opcode_error pulses once, opcode_error_data equals the full 128-bit input, last_timestamp=0xABCD, and DDS outputs are unchanged.
